// File: rtl/sad_scan_controller_pkg.sv
// Shared types and constants for the SAD scan controller.
// The optional early-exit feature is enabled by defining SAD_EARLY_EXIT_EN.
package sad_scan_controller_pkg;

  localparam int POS_W_DEF = 6;
  localparam int SAD_W_DEF = 32;

  // Wide enough for any SAD_W up to 64; users truncate to their width.
  localparam logic [63:0] SAD_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_CMP,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/sad_scan_controller_if.sv
// Bundle of scan control, window handshake and result signals.
// The master side is the scan controller; the slave side is the SAD datapath/host.
interface sad_scan_controller_if
  import sad_scan_controller_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int SAD_W = SAD_W_DEF
) ();

  logic             Start;
  logic [POS_W-1:0] SearchRows;
  logic [POS_W-1:0] SearchCols;
  logic             WinReq;
  logic [POS_W-1:0] WinRow;
  logic [POS_W-1:0] WinCol;
  logic             WinAck;
  logic             SadValid;
  logic [SAD_W-1:0] SadValue;
  logic             Busy;
  logic             Done;
  logic [SAD_W-1:0] MinSad;
  logic [POS_W-1:0] MinRow;
  logic [POS_W-1:0] MinCol;
  logic             minRegWrite;

  modport master (
    input  Start, SearchRows, SearchCols, WinAck, SadValid, SadValue,
    output WinReq, WinRow, WinCol, Busy, Done, MinSad, MinRow, MinCol, minRegWrite
  );

  modport slave (
    output Start, SearchRows, SearchCols, WinAck, SadValid, SadValue,
    input  WinReq, WinRow, WinCol, Busy, Done, MinSad, MinRow, MinCol, minRegWrite
  );

endinterface

// File: rtl/sad_scan_controller_pos_counter.sv
// Row-major candidate position counter (module sad_pos_counter).
// Column wraps at cols-1 into the next row; last flags the final position.
module sad_pos_counter #(
  parameter int POS_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [POS_W-1:0] rows,
  input  logic [POS_W-1:0] cols,
  output logic [POS_W-1:0] row,
  output logic [POS_W-1:0] col,
  output logic             last
);

  logic col_end;

  assign col_end = (col == cols - POS_W'(1));
  assign last    = col_end && (row == rows - POS_W'(1));

  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row + POS_W'(1);
      end else begin
        col <= col + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/sad_scan_controller.sv
// Scans a SearchRows x SearchCols area, requesting one SAD per position and tracking the minimum.
// Define SAD_EARLY_EXIT_EN to end the scan as soon as a SAD of zero is seen.
//
// state   | meaning
// IDLE    | waiting for Start
// REQ     | WinReq held at current position until WinAck
// WAIT    | waiting for SadValid, SAD captured on arrival
// CMP     | compare with MinSad, advance position or finish
// DONE    | one-cycle Done pulse
module sad_scan_controller
  import sad_scan_controller_pkg::*;
#(
  parameter int POS_W = POS_W_DEF,
  parameter int SAD_W = SAD_W_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  sad_scan_controller_if.master bus
);

  localparam logic [SAD_W-1:0] SAD_MAX = SAD_W'(SAD_ONES);

  scan_state_t      state;
  logic [POS_W-1:0] rows_q;
  logic [POS_W-1:0] cols_q;
  logic [POS_W-1:0] row;
  logic [POS_W-1:0] col;
  logic [SAD_W-1:0] sad_q;
  logic             last;
  logic             start_ok;
  logic             cmp_better;
  logic             cmp_finish;
  logic             pos_advance;

  assign start_ok   = (state == ST_IDLE) && bus.Start;
  assign cmp_better = (sad_q < bus.MinSad);

`ifdef SAD_EARLY_EXIT_EN
  // A zero SAD cannot be beaten, so the rest of the area need not be scanned.
  assign cmp_finish = last || (sad_q == '0);
`else
  assign cmp_finish = last;
`endif

  assign pos_advance = (state == ST_CMP) && !cmp_finish;

  sad_pos_counter #(.POS_W(POS_W)) u_pos (
    .Clk     (Clk),
    .Reset   (Reset),
    .clear   (start_ok),
    .advance (pos_advance),
    .rows    (rows_q),
    .cols    (cols_q),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  assign bus.WinRow = row;
  assign bus.WinCol = col;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state           <= ST_IDLE;
      rows_q          <= '0;
      cols_q          <= '0;
      sad_q           <= '0;
      bus.WinReq      <= 1'b0;
      bus.Busy        <= 1'b0;
      bus.Done        <= 1'b0;
      bus.minRegWrite <= 1'b0;
      bus.MinSad      <= SAD_MAX;
      bus.MinRow      <= '0;
      bus.MinCol      <= '0;
    end else begin
      bus.Done        <= 1'b0;
      bus.minRegWrite <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Start) begin
            rows_q     <= bus.SearchRows;
            cols_q     <= bus.SearchCols;
            bus.MinSad <= SAD_MAX;
            bus.MinRow <= '0;
            bus.MinCol <= '0;
            bus.Busy   <= 1'b1;
            if (bus.SearchRows == '0 || bus.SearchCols == '0) begin
              state    <= ST_DONE;
              bus.Done <= 1'b1;
            end else begin
              state      <= ST_REQ;
              bus.WinReq <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (bus.WinAck) begin
            bus.WinReq <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.SadValid) begin
            sad_q <= bus.SadValue;
            state <= ST_CMP;
          end
        end
        ST_CMP: begin
          // Strict compare: on a tie the earlier position is kept.
          if (cmp_better) begin
            bus.MinSad      <= sad_q;
            bus.MinRow      <= row;
            bus.MinCol      <= col;
            bus.minRegWrite <= 1'b1;
          end
          if (cmp_finish) begin
            state    <= ST_DONE;
            bus.Done <= 1'b1;
          end else begin
            state      <= ST_REQ;
            bus.WinReq <= 1'b1;
          end
        end
        ST_DONE: begin
          bus.Busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_scan_controller.sv
// Bench for sad_scan_controller: directed table of scans, hand-written reset sequences,
// and randomized scans checked against a row-major minimum-search model.
module tb_sad_scan_controller;
  import sad_scan_controller_pkg::*;

  localparam int POS_W = 6;
  localparam int SAD_W = 32;
  localparam logic [SAD_W-1:0] ONES = '1;
`ifdef SAD_EARLY_EXIT_EN
  localparam int EE_NPOS = 4;
  localparam bit EARLY = 1'b1;
`else
  localparam int EE_NPOS = 9;
  localparam bit EARLY = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sad_scan_controller_if #(.POS_W(POS_W), .SAD_W(SAD_W)) bus ();

  sad_scan_controller #(.POS_W(POS_W), .SAD_W(SAD_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.master)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  logic [SAD_W-1:0] sads [64];

  int r_done, r_mrw, r_npos, r_reqhi, r_order_bad, r_stable_bad, r_busy_low, r_lat;
  int r_post_busy, r_post_done, r_timeout;

  // Acts as the SAD datapath: acks after ack_dly extra REQ cycles, returns SAD after val_dly extra WAIT cycles.
  task automatic run_scan(input int rows, input int cols, input int ack_dly, input int val_dly,
                          input bit spur, input bit sbusy);
    int phase = 0;
    int cnt   = 0;
    int cr    = 0;
    int cc    = 0;
    int cyc   = 0;
    bit fin   = 1'b0;
    r_done = 0; r_mrw = 0; r_npos = 0; r_reqhi = 0; r_order_bad = 0; r_stable_bad = 0;
    r_busy_low = 0; r_lat = -1; r_post_busy = 0; r_post_done = 0; r_timeout = 0;
    @(negedge Clk);
    bus.Start      = 1'b1;
    bus.SearchRows = POS_W'(rows);
    bus.SearchCols = POS_W'(cols);
    while (!fin && cyc < 3000) begin
      @(negedge Clk);
      cyc++;
      bus.Start = 1'b0;
      if (bus.minRegWrite) r_mrw++;
      if (bus.WinReq) r_reqhi++;
      if (!bus.Busy) r_busy_low++;
      if (bus.Done) begin
        r_done++;
        r_lat = cyc;
        if (sbusy) begin
          bus.Start = 1'b1; bus.SearchRows = 2; bus.SearchCols = 2;
        end
        @(negedge Clk);
        bus.Start   = 1'b0;
        r_post_busy = int'(bus.Busy);
        r_post_done = int'(bus.Done);
        fin = 1'b1;
      end else begin
        case (phase)
          0: if (bus.WinReq) begin
               if (cnt == 0) begin
                 cr = int'(bus.WinRow);
                 cc = int'(bus.WinCol);
                 if (cols == 0 || cr != r_npos / cols || cc != r_npos % cols) r_order_bad++;
               end else if (int'(bus.WinRow) != cr || int'(bus.WinCol) != cc) begin
                 r_stable_bad++;
               end
               bus.SadValid = spur && cnt == 0 && ack_dly > 0;
               bus.SadValue = '0;
               if (cnt == ack_dly) begin
                 bus.WinAck = 1'b1; phase = 1; cnt = 0; r_npos++;
               end else begin
                 cnt++;
               end
             end
          1: begin
               bus.WinAck   = 1'b0;
               bus.SadValid = 1'b0;
               if (cnt == val_dly) begin
                 bus.SadValid = 1'b1;
                 bus.SadValue = sads[(cr * cols + cc) % 64];
                 phase = 2;
               end else begin
                 cnt++;
               end
             end
          default: begin
               bus.SadValid = 1'b0;
               phase = 0;
               cnt   = 0;
               if (sbusy) begin
                 bus.Start = 1'b1; bus.SearchRows = 1; bus.SearchCols = 1;
               end
             end
        endcase
      end
    end
    if (!fin) r_timeout = 1;
    bus.WinAck = 1'b0; bus.SadValid = 1'b0; bus.Start = 1'b0;
  endtask

  task automatic verify(input string tag, input int ack_dly, input int val_dly,
                        input logic [SAD_W-1:0] emin, input int erow, input int ecol,
                        input int emrw, input int enpos);
    check({tag, " timeout"}, r_timeout, 0);
    check({tag, " done_count"}, r_done, 1);
    check({tag, " positions"}, r_npos, enpos);
    check({tag, " min_sad"}, bus.MinSad, emin);
    check({tag, " min_row"}, bus.MinRow, erow);
    check({tag, " min_col"}, bus.MinCol, ecol);
    check({tag, " reg_write_pulses"}, r_mrw, emrw);
    check({tag, " winreq_cycles"}, r_reqhi, enpos * (ack_dly + 1));
    check({tag, " order_errors"}, r_order_bad, 0);
    check({tag, " pos_unstable"}, r_stable_bad, 0);
    check({tag, " busy_dropped"}, r_busy_low, 0);
    check({tag, " done_latency"}, r_lat, enpos * (3 + ack_dly + val_dly) + 1);
    check({tag, " busy_after_done"}, r_post_busy, 0);
    check({tag, " done_width"}, r_post_done, 0);
  endtask

  typedef struct {
    int               rows, cols, ack, val;
    bit               spur, sbusy;
    logic [SAD_W-1:0] sv [9];
    logic [SAD_W-1:0] emin;
    int               erow, ecol, emrw, enpos;
  } vec_t;

  vec_t vt [8];

  initial begin
    int dcount;
    logic [SAD_W-1:0] em;
    int er, ec, emrw, en, rows, cols, ack, val;
    bit stop;

    vt[0] = '{2, 2, 0, 0, 1'b0, 1'b0, '{9, 4, 7, 4, 0, 0, 0, 0, 0}, 4, 0, 1, 2, 4};
    vt[1] = '{2, 2, 5, 0, 1'b0, 1'b0, '{9, 4, 7, 4, 0, 0, 0, 0, 0}, 4, 0, 1, 2, 4};
    vt[2] = '{0, 3, 0, 0, 1'b0, 1'b0, '{1, 1, 1, 1, 1, 1, 1, 1, 1}, ONES, 0, 0, 0, 0};
    vt[3] = '{3, 0, 0, 0, 1'b0, 1'b1, '{1, 1, 1, 1, 1, 1, 1, 1, 1}, ONES, 0, 0, 0, 0};
    vt[4] = '{3, 3, 0, 0, 1'b0, 1'b0, '{5, 6, 7, 0, 3, 2, 8, 9, 1}, 0, 1, 0, 2, EE_NPOS};
    vt[5] = '{3, 3, 2, 3, 1'b1, 1'b1, '{7, 3, 3, 9, 2, 2, 5, 6, 2}, 2, 1, 1, 3, 9};
    vt[6] = '{1, 1, 1, 1, 1'b1, 1'b0, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 0, 0, 1, 1};
    vt[7] = '{1, 2, 1, 0, 1'b1, 1'b1, '{ONES, ONES, 0, 0, 0, 0, 0, 0, 0}, ONES, 0, 0, 0, 2};

    bus.Start = 1'b0; bus.SearchRows = '0; bus.SearchCols = '0;
    bus.WinAck = 1'b0; bus.SadValid = 1'b0; bus.SadValue = '0;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst winreq", bus.WinReq, 0);
    check("rst busy", bus.Busy, 0);
    check("rst done", bus.Done, 0);
    check("rst reg_write", bus.minRegWrite, 0);
    check("rst winrow", bus.WinRow, 0);
    check("rst wincol", bus.WinCol, 0);
    check("rst min_sad", bus.MinSad, ONES);
    check("rst min_row", bus.MinRow, 0);
    check("rst min_col", bus.MinCol, 0);
    Reset = 1'b0;

    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 64; i++) sads[i] = (i < 9) ? vt[t].sv[i] : '0;
      run_scan(vt[t].rows, vt[t].cols, vt[t].ack, vt[t].val, vt[t].spur, vt[t].sbusy);
      verify($sformatf("vec%0d", t), vt[t].ack, vt[t].val, vt[t].emin, vt[t].erow,
             vt[t].ecol, vt[t].emrw, vt[t].enpos);
    end

    // Reset in the WAIT state of the second position of a 3x3 scan.
    @(negedge Clk);
    bus.Start = 1'b1; bus.SearchRows = 3; bus.SearchCols = 3;
    @(negedge Clk);
    bus.Start = 1'b0;
    check("rstseq winreq", bus.WinReq, 1);
    bus.WinAck = 1'b1;
    @(negedge Clk);
    bus.WinAck = 1'b0; bus.SadValid = 1'b1; bus.SadValue = 5;
    @(negedge Clk);
    bus.SadValid = 1'b0;
    @(negedge Clk);
    check("rstseq min_before", bus.MinSad, 5);
    check("rstseq col_before", bus.WinCol, 1);
    bus.WinAck = 1'b1;
    @(negedge Clk);
    bus.WinAck = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    check("rstseq busy", bus.Busy, 0);
    check("rstseq winreq_off", bus.WinReq, 0);
    check("rstseq min_sad", bus.MinSad, ONES);
    check("rstseq min_col", bus.MinCol, 0);
    check("rstseq wincol", bus.WinCol, 0);
    bus.Start = 1'b1; bus.SearchRows = 2; bus.SearchCols = 2;
    @(negedge Clk);
    check("rstseq reset_beats_start", bus.Busy, 0);
    Reset = 1'b0; bus.Start = 1'b0;
    dcount = 0;
    repeat (12) begin
      @(negedge Clk);
      if (bus.Done || bus.Busy) dcount++;
    end
    check("rstseq no_done", dcount, 0);

    // Randomized scans against the row-major minimum-search model.
    for (int t = 0; t < 10; t++) begin
      rows = $urandom_range(1, 4);
      cols = $urandom_range(1, 4);
      ack  = $urandom_range(0, 2);
      val  = $urandom_range(0, 2);
      for (int i = 0; i < 64; i++) sads[i] = SAD_W'($urandom_range(0, 12));
      em = ONES; er = 0; ec = 0; emrw = 0; en = 0; stop = 1'b0;
      for (int r = 0; r < rows; r++) begin
        for (int c = 0; c < cols; c++) begin
          if (!stop) begin
            en++;
            if (sads[r * cols + c] < em) begin
              em = sads[r * cols + c]; er = r; ec = c; emrw++;
            end
            if (EARLY && sads[r * cols + c] == 0) stop = 1'b1;
          end
        end
      end
      run_scan(rows, cols, ack, val, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      verify($sformatf("rand%0d", t), ack, val, em, er, ec, emrw, en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
